// File: rtl/control_sequencer_if.sv
// Memory-side handshake bundle for control_sequencer: instruction fetch
// request/ready, the fetched instruction word and data-access completion.
interface control_sequencer_if;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] instr;
    logic        dmem_ready;

    modport master (output imem_req, input imem_ready, input instr, input dmem_ready);
    modport slave  (input imem_req, output imem_ready, output instr, output dmem_ready);
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for a small RISC-V style datapath.
// Optional retired-instruction counter enabled by defining CTRL_RETIRE_CNT_EN.
module control_sequencer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    control_sequencer_if.master        mem,
    input  logic                       branch_taken,
    output logic                       ir_write,
    output logic                       pc_write,
    output logic                       pc_src,
    output logic                       alu_src,
    output logic                       reg_write,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic                       mem_to_reg,
    output logic [16:0]                imm_field,
    output logic [1:0]                 immsel,
    output logic                       illegal,
    output logic                       mem_timeout,
    output logic [2:0]                 state
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0]                retired
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_ILLEGAL
    } op_e;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    function automatic op_e classify(input logic [6:0] opcode);
        case (opcode)
            7'b0110011: classify = OP_R;
            7'b0010011: classify = OP_IALU;
            7'b0000011: classify = OP_LOAD;
            7'b0100011: classify = OP_STORE;
            7'b1100011: classify = OP_BRANCH;
            default:    classify = OP_ILLEGAL;
        endcase
    endfunction

    function automatic logic [1:0] immselFor(input op_e op);
        case (op)
            OP_IALU, OP_LOAD: immselFor = 2'b00;
            OP_STORE:         immselFor = 2'b01;
            OP_BRANCH:        immselFor = 2'b10;
            default:          immselFor = 2'b11;
        endcase
    endfunction

    state_e      state_q;
    logic [31:0] ir_q;
    logic [1:0]  immsel_q;
    logic        alu_src_q;
    logic [7:0]  wait_q;
    op_e         op;
    op_e         fetchOp;
    logic        memDone;
    logic        ir_unused;

    assign op        = classify(ir_q[6:0]);
    assign fetchOp   = classify(mem.instr[6:0]);
    assign ir_unused = ^ir_q[19:12];

    // Strobes are decoded from the registered state so reset removes them immediately.
    assign mem.imem_req = (state_q == FETCH);
    assign ir_write     = (state_q == FETCH) && mem.imem_ready;
    assign illegal      = (state_q == DECODE) && (op == OP_ILLEGAL);
    assign memDone      = (state_q == MEM) && mem.dmem_ready;
    assign mem_timeout  = (state_q == MEM) && !mem.dmem_ready && (wait_q == WAIT_LAST);
    assign pc_write     = illegal
                        || ((state_q == EXEC) && (op == OP_BRANCH))
                        || (memDone && (op == OP_STORE))
                        || mem_timeout
                        || (state_q == WB);
    assign pc_src       = (state_q == EXEC) && (op == OP_BRANCH) && branch_taken;
    assign reg_write    = (state_q == WB);
    assign mem_to_reg   = (state_q == WB) && (op == OP_LOAD);
    assign mem_read     = (state_q == MEM) && (op == OP_LOAD);
    assign mem_write    = (state_q == MEM) && (op == OP_STORE);
    assign imm_field    = {ir_q[31:20], ir_q[11:7]};
    assign immsel       = immsel_q;
    assign alu_src      = alu_src_q;
    assign state        = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            immsel_q  <= 2'b11;
            alu_src_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (mem.imem_ready) begin
                        ir_q      <= mem.instr;
                        immsel_q  <= immselFor(fetchOp);
                        alu_src_q <= (fetchOp == OP_IALU) || (fetchOp == OP_LOAD)
                                     || (fetchOp == OP_STORE);
                        state_q   <= DECODE;
                    end
                end
                DECODE: begin
                    state_q <= (op == OP_ILLEGAL) ? FETCH : EXEC;
                end
                EXEC: begin
                    wait_q <= '0;
                    case (op)
                        OP_R, OP_IALU:     state_q <= WB;
                        OP_LOAD, OP_STORE: state_q <= MEM;
                        default:           state_q <= FETCH;
                    endcase
                end
                MEM: begin
                    // A ready arriving on the last allowed cycle still completes the access.
                    if (mem.dmem_ready) begin
                        state_q <= (op == OP_LOAD) ? WB : FETCH;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= FETCH;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                WB: begin
                    state_q <= FETCH;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retired_q;
    logic        retire;

    assign retire = (state_q == WB)
                 || ((state_q == EXEC) && (op == OP_BRANCH))
                 || (memDone && (op == OP_STORE));
    assign retired = retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end
`endif

endmodule
